// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: MEMOP size encodings, the stage FSM
// state type and the alignment rule used to reject misaligned accesses.
package mem_pkg;

  // MEMOP = {unsigned, size[1:0]}
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int unsigned OpUnsBit = 2;

  typedef enum logic [0:0] {IDLE, ACCESS} mem_state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    unique case (size)
      SZ_B:        mis = 1'b0;
      SZ_H:        mis = off[0];
      SZ_W, 2'b11: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter for a 32-bit little-endian data port.
// Also used by the instruction-fetch path.
//   size_i      access size (SZ_B/SZ_H/SZ_W; 2'b11 acts as word)
//   off_i       byte offset within the word (addr[1:0])
//   unsigned_i  zero-extend sub-word loads when set
//   storedata_i store source register
//   rdata_i     raw word read from memory
//   be_o        byte enables
//   wdata_o     store data replicated across lanes
//   loaddata_o  load data shifted down and extended
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] storedata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loaddata_o
);

  logic [31:0] shifted;
  logic        sext_b;
  logic        sext_h;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    sext_b  = ~unsigned_i & shifted[7];
    sext_h  = ~unsigned_i & shifted[15];

    be_o       = 4'b1111;
    wdata_o    = storedata_i;
    loaddata_o = shifted;
    case (size_i)
      SZ_B: begin
        be_o       = 4'b0001 << off_i;
        wdata_o    = {4{storedata_i[7:0]}};
        loaddata_o = {{24{sext_b}}, shifted[7:0]};
      end
      SZ_H: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{storedata_i[15:0]}};
        loaddata_o = {{16{sext_h}}, shifted[15:0]};
      end
      default: begin
        be_o       = 4'b1111;
        wdata_o    = storedata_i;
        loaddata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues byte/half/word loads and stores to a
// variable-latency data memory over a req/ack handshake, stalls EX while an
// access is outstanding, and hands the result to the writeback stage.
//   clk, rst            clock and synchronous active-high reset
//   valid_E ... storedata_E   instruction from EX
//   dm_req/we/addr/be/wdata   memory request (held stable until dm_ack)
//   dm_rdata, dm_ack          memory response
//   stall_M             EX must hold its inputs
//   misalign_M          one-cycle flag for misaligned access or timeout
//   MEM2REG_M, REGWR_M, reg2wr_M, memdata_M, aludata_M   to writeback
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_E,
  input  logic          MEMRD_E,
  input  logic          MEMWR_E,
  input  logic          MEM2REG_E,
  input  logic          REGWR_E,
  input  logic [2:0]    MEMOP_E,
  input  logic [4:0]    reg2wr_E,
  input  logic [31:0]   aludata_E,
  input  logic [31:0]   storedata_E,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  input  logic          dm_ack,
  output logic          stall_M,
  output logic          misalign_M,
  output logic          MEM2REG_M,
  output logic          REGWR_M,
  output logic [4:0]    reg2wr_M,
  output logic [31:0]   memdata_M,
  output logic [31:0]   aludata_M
);

  mem_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Instruction captured when the access is launched
  logic        h_load_q, h_load_d;
  logic        h_m2r_q, h_m2r_d;
  logic        h_regwr_q, h_regwr_d;
  logic [4:0]  h_reg_q, h_reg_d;
  logic [31:0] h_alu_q, h_alu_d;
  logic [1:0]  h_size_q, h_size_d;
  logic        h_uns_q, h_uns_d;

  // Registered outputs
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mis_q, mis_d;
  logic          m2r_q, m2r_d;
  logic          regwr_q, regwr_d;
  logic [4:0]    reg_q, reg_d;
  logic [31:0]   memdata_q, memdata_d;
  logic [31:0]   alu_q, alu_d;

  // One formatter serves both phases: in IDLE it builds the request from the
  // EX inputs, in ACCESS it formats the returning data from the held op.
  logic        in_idle;
  logic [1:0]  fmt_size;
  logic [1:0]  fmt_off;
  logic        fmt_uns;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;

  assign in_idle  = (state_q == IDLE);
  assign fmt_size = in_idle ? MEMOP_E[1:0] : h_size_q;
  assign fmt_off  = in_idle ? aludata_E[1:0] : h_alu_q[1:0];
  assign fmt_uns  = in_idle ? MEMOP_E[OpUnsBit] : h_uns_q;

  mem_lane_fmt u_lane_fmt (
    .size_i      (fmt_size),
    .off_i       (fmt_off),
    .unsigned_i  (fmt_uns),
    .storedata_i (storedata_E),
    .rdata_i     (dm_rdata),
    .be_o        (fmt_be),
    .wdata_o     (fmt_wdata),
    .loaddata_o  (fmt_load)
  );

  logic is_mem;
  assign is_mem = MEMRD_E | MEMWR_E;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_load_d  = h_load_q;
    h_m2r_d   = h_m2r_q;
    h_regwr_d = h_regwr_q;
    h_reg_d   = h_reg_q;
    h_alu_d   = h_alu_q;
    h_size_d  = h_size_q;
    h_uns_d   = h_uns_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mis_d     = 1'b0;
    m2r_d     = m2r_q;
    regwr_d   = regwr_q;
    reg_d     = reg_q;
    memdata_d = memdata_q;
    alu_d     = alu_q;

    unique case (state_q)
      IDLE: begin
        if (!valid_E) begin
          regwr_d = 1'b0;
        end else if (!is_mem) begin
          m2r_d   = MEM2REG_E;
          regwr_d = REGWR_E;
          reg_d   = reg2wr_E;
          alu_d   = aludata_E;
        end else if (is_misaligned(MEMOP_E[1:0], aludata_E[1:0])) begin
          mis_d   = 1'b1;
          regwr_d = 1'b0;
        end else begin
          // Both MEMRD_E and MEMWR_E set counts as a store
          h_load_d  = ~MEMWR_E;
          h_m2r_d   = MEM2REG_E;
          h_regwr_d = REGWR_E;
          h_reg_d   = reg2wr_E;
          h_alu_d   = aludata_E;
          h_size_d  = MEMOP_E[1:0];
          h_uns_d   = MEMOP_E[OpUnsBit];
          req_d     = 1'b1;
          we_d      = MEMWR_E;
          addr_d    = {aludata_E[AW-1:2], 2'b00};
          be_d      = fmt_be;
          wdata_d   = fmt_wdata;
          regwr_d   = 1'b0;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (h_load_q) begin
            memdata_d = fmt_load;
            regwr_d   = h_regwr_q;
            m2r_d     = h_m2r_q;
            reg_d     = h_reg_q;
            alu_d     = h_alu_q;
          end else begin
            regwr_d = 1'b0;
          end
        end else if ((TIMEOUT != 0) && ((cnt_q + 32'd1) >= 32'(TIMEOUT))) begin
          req_d   = 1'b0;
          mis_d   = 1'b1;
          regwr_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      h_load_q  <= 1'b0;
      h_m2r_q   <= 1'b0;
      h_regwr_q <= 1'b0;
      h_reg_q   <= '0;
      h_alu_q   <= '0;
      h_size_q  <= '0;
      h_uns_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      m2r_q     <= 1'b0;
      regwr_q   <= 1'b0;
      reg_q     <= '0;
      memdata_q <= '0;
      alu_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_load_q  <= h_load_d;
      h_m2r_q   <= h_m2r_d;
      h_regwr_q <= h_regwr_d;
      h_reg_q   <= h_reg_d;
      h_alu_q   <= h_alu_d;
      h_size_q  <= h_size_d;
      h_uns_q   <= h_uns_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      m2r_q     <= m2r_d;
      regwr_q   <= regwr_d;
      reg_q     <= reg_d;
      memdata_q <= memdata_d;
      alu_q     <= alu_d;
    end
  end

  assign stall_M    = (state_q == ACCESS);
  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_be      = be_q;
  assign dm_wdata   = wdata_q;
  assign misalign_M = mis_q;
  assign MEM2REG_M  = m2r_q;
  assign REGWR_M    = regwr_q;
  assign reg2wr_M   = reg_q;
  assign memdata_M  = memdata_q;
  assign aludata_M  = alu_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a directed prefix from the test plan followed
// by random instructions, random memory wait states and random idle-time acks,
// all checked every cycle against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E, MEMRD_E, MEMWR_E, MEM2REG_E, REGWR_E;
  logic [2:0]  MEMOP_E;
  logic [4:0]  reg2wr_E;
  logic [31:0] aludata_E, storedata_E;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        stall_M, misalign_M, MEM2REG_M, REGWR_M;
  logic [4:0]  reg2wr_M;
  logic [31:0] memdata_M, aludata_M;

  mem_stage #(.AW(32), .TIMEOUT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_E     (valid_E),
    .MEMRD_E     (MEMRD_E),
    .MEMWR_E     (MEMWR_E),
    .MEM2REG_E   (MEM2REG_E),
    .REGWR_E     (REGWR_E),
    .MEMOP_E     (MEMOP_E),
    .reg2wr_E    (reg2wr_E),
    .aludata_E   (aludata_E),
    .storedata_E (storedata_E),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_be       (dm_be),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .stall_M     (stall_M),
    .misalign_M  (misalign_M),
    .MEM2REG_M   (MEM2REG_M),
    .REGWR_M     (REGWR_M),
    .reg2wr_M    (reg2wr_M),
    .memdata_M   (memdata_M),
    .aludata_M   (aludata_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, m2r, regwr;
    logic [2:0]  op;
    logic [4:0]  rdst;
    logic [31:0] alu, sd, rdata;
    int unsigned wait_n;
  } instr_t;

  instr_t prog[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules, written as plain arithmetic on sizes and offsets
  function automatic bit ref_misal(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] sd);
    if (size == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [2:0] op);
    logic [31:0] r, v;
    r = rdata >> (8 * off);
    if (op[1:0] == 2'd0) begin
      v = r % 256;
      if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op[1:0] == 2'd1) begin
      v = r % 65536;
      if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // Model state and expected outputs
  bit          busy;
  int unsigned wleft;
  instr_t      cur;
  int          idx;
  logic        e_req, e_we, e_mis, e_regwr, e_m2r, e_wb_load;
  logic [31:0] e_addr, e_wdata, e_mem, e_alu;
  logic [3:0]  e_be;
  logic [4:0]  e_reg;

  task automatic model_edge();
    e_mis = 1'b0;
    if (!busy) begin
      if (!valid_E) begin
        e_regwr = 1'b0;
      end else begin
        if (!(MEMRD_E || MEMWR_E)) begin
          e_regwr   = REGWR_E;
          e_m2r     = MEM2REG_E;
          e_reg     = reg2wr_E;
          e_alu     = aludata_E;
          e_wb_load = 1'b0;
        end else if (ref_misal(MEMOP_E[1:0], aludata_E[1:0])) begin
          e_mis   = 1'b1;
          e_regwr = 1'b0;
        end else begin
          busy    = 1'b1;
          cur     = prog[idx];
          wleft   = cur.wait_n;
          e_req   = 1'b1;
          e_we    = MEMWR_E;
          e_addr  = aludata_E - (aludata_E % 4);
          e_be    = ref_be(MEMOP_E[1:0], aludata_E[1:0]);
          e_wdata = ref_wdata(MEMOP_E[1:0], storedata_E);
          e_regwr = 1'b0;
        end
        idx++;
      end
    end else if (dm_ack) begin
      busy  = 1'b0;
      e_req = 1'b0;
      if (cur.rd && !cur.wr) begin
        e_mem     = ref_load(dm_rdata, cur.alu[1:0], cur.op);
        e_regwr   = cur.regwr;
        e_m2r     = cur.m2r;
        e_reg     = cur.rdst;
        e_wb_load = 1'b1;
      end else begin
        e_regwr = 1'b0;
      end
    end else begin
      wleft--;
    end
  endtask

  task automatic check_outputs();
    check_eq("dm_req", 32'(dm_req), 32'(e_req));
    check_eq("stall_M", 32'(stall_M), 32'(busy));
    check_eq("misalign_M", 32'(misalign_M), 32'(e_mis));
    check_eq("REGWR_M", 32'(REGWR_M), 32'(e_regwr));
    check_eq("memdata_M", memdata_M, e_mem);
    if (e_req) begin
      check_eq("dm_we", 32'(dm_we), 32'(e_we));
      check_eq("dm_addr", dm_addr, e_addr);
      check_eq("dm_be", 32'(dm_be), 32'(e_be));
      check_eq("dm_wdata", dm_wdata, e_wdata);
    end
    if (e_regwr) begin
      check_eq("reg2wr_M", 32'(reg2wr_M), 32'(e_reg));
      check_eq("MEM2REG_M", 32'(MEM2REG_M), 32'(e_m2r));
      if (!e_wb_load) check_eq("aludata_M", aludata_M, e_alu);
    end
  endtask

  task automatic drive_instr(input instr_t in);
    valid_E     = 1'b1;
    MEMRD_E     = in.rd;
    MEMWR_E     = in.wr;
    MEM2REG_E   = in.m2r;
    REGWR_E     = in.regwr;
    MEMOP_E     = in.op;
    reg2wr_E    = in.rdst;
    aludata_E   = in.alu;
    storedata_E = in.sd;
  endtask

  function automatic instr_t mk(input logic rd, input logic wr, input logic m2r,
                                input logic regwr, input logic [2:0] op, input logic [4:0] rdst,
                                input logic [31:0] alu, input logic [31:0] sd,
                                input logic [31:0] rdata, input int unsigned wait_n);
    instr_t t;
    t.rd = rd; t.wr = wr; t.m2r = m2r; t.regwr = regwr; t.op = op; t.rdst = rdst;
    t.alu = alu; t.sd = sd; t.rdata = rdata; t.wait_n = wait_n;
    return t;
  endfunction

  localparam int NDir  = 7;
  localparam int NRand = 160;

  initial begin
    instr_t t;
    int     cycles;
    int     kind;

    // Directed prefix
    prog.push_back(mk(0, 0, 0, 1, 3'b010, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0));
    prog.push_back(mk(1, 0, 1, 1, 3'b000, 5'd6, 32'h0000_0103, 32'h0, 32'h80FF_0011, 0));
    prog.push_back(mk(1, 0, 1, 1, 3'b100, 5'd6, 32'h0000_0103, 32'h0, 32'h80FF_0011, 0));
    prog.push_back(mk(0, 1, 0, 0, 3'b001, 5'd0, 32'h0000_0202, 32'hABCD_1234, 32'h0, 3));
    prog.push_back(mk(1, 0, 1, 1, 3'b010, 5'd4, 32'h0000_0101, 32'h0, 32'h0, 0));
    prog.push_back(mk(1, 0, 1, 1, 3'b010, 5'd7, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1));
    prog.push_back(mk(0, 0, 0, 1, 3'b010, 5'd8, 32'h0000_5555, 32'h0, 32'h0, 0));
    for (int i = 0; i < NRand; i++) begin
      kind = $urandom_range(3);
      t = mk(kind == 1 || kind == 3, kind >= 2, 1'($urandom), 1'($urandom), 3'($urandom),
             5'($urandom), $urandom, $urandom, $urandom, $urandom_range(3));
      prog.push_back(t);
    end

    rst = 1'b1; valid_E = 1'b0; MEMRD_E = 1'b0; MEMWR_E = 1'b0; MEM2REG_E = 1'b0;
    REGWR_E = 1'b0; MEMOP_E = '0; reg2wr_E = '0; aludata_E = '0; storedata_E = '0;
    dm_rdata = '0; dm_ack = 1'b0;
    busy = 0; wleft = 0; idx = 0;
    e_req = 0; e_we = 0; e_mis = 0; e_regwr = 0; e_m2r = 0; e_wb_load = 0;
    e_addr = '0; e_wdata = '0; e_mem = '0; e_alu = '0; e_be = '0; e_reg = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst dm_req", 32'(dm_req), 32'd0);
    check_eq("rst stall_M", 32'(stall_M), 32'd0);
    check_eq("rst REGWR_M", 32'(REGWR_M), 32'd0);
    check_eq("rst misalign_M", 32'(misalign_M), 32'd0);
    check_eq("rst memdata_M", memdata_M, 32'd0);
    check_eq("rst aludata_M", aludata_M, 32'd0);
    check_eq("rst dm_be", 32'(dm_be), 32'd0);
    rst = 1'b0;

    cycles = 0;
    while ((idx < prog.size() || busy) && cycles < 5000) begin
      // Inputs for the coming edge; EX keeps presenting prog[idx] while stalled
      if (idx < prog.size() && (busy || idx < NDir || $urandom_range(4) != 0)) begin
        drive_instr(prog[idx]);
      end else begin
        valid_E     = 1'b0;
        MEMRD_E     = 1'($urandom);
        MEMWR_E     = 1'($urandom);
        REGWR_E     = 1'($urandom);
        aludata_E   = $urandom;
      end
      if (busy) begin
        dm_ack   = (wleft == 0);
        dm_rdata = dm_ack ? cur.rdata : $urandom;
      end else begin
        dm_ack   = 1'($urandom);
        dm_rdata = $urandom;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      cycles++;
    end
    check_eq("program drained", 32'(idx == prog.size() && !busy), 32'd1);

    // Reset in the middle of an access, then a late ack
    drive_instr(mk(1, 0, 1, 1, 3'b010, 5'd3, 32'h0000_0040, 32'h0, 32'h0, 0));
    dm_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre-rst dm_req", 32'(dm_req), 32'd1);
    check_eq("pre-rst stall_M", 32'(stall_M), 32'd1);
    valid_E = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid-rst dm_req", 32'(dm_req), 32'd0);
    check_eq("mid-rst stall_M", 32'(stall_M), 32'd0);
    check_eq("mid-rst REGWR_M", 32'(REGWR_M), 32'd0);
    check_eq("mid-rst memdata_M", memdata_M, 32'd0);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    dm_ack = 1'b0;
    check_eq("late ack REGWR_M", 32'(REGWR_M), 32'd0);
    check_eq("late ack dm_req", 32'(dm_req), 32'd0);
    check_eq("late ack stall_M", 32'(stall_M), 32'd0);
    check_eq("late ack memdata_M", memdata_M, 32'd0);
    drive_instr(mk(0, 0, 0, 1, 3'b000, 5'd9, 32'h0BAD_BEEF, 32'h0, 32'h0, 0));
    @(posedge clk);
    @(negedge clk);
    valid_E = 1'b0;
    check_eq("post-rst REGWR_M", 32'(REGWR_M), 32'd1);
    check_eq("post-rst reg2wr_M", 32'(reg2wr_M), 32'd9);
    check_eq("post-rst aludata_M", aludata_M, 32'h0BAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
